// File: rtl/game_ctl.sv
// Game-flow controller: start/countdown/play/pause/end sequencing, scoring and winner decision.
// Optional end-screen timeout is enabled by defining GAME_CTL_TIMEOUT_EN.
module game_ctl #(
  parameter int WIN_SCORE    = 5,
  parameter int READY_FRAMES = 180,
  parameter int END_FRAMES   = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [5:0] state_bin,
  output logic [1:0] resoult,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2
);

  typedef enum logic [5:0] {
    S_INIT   = 6'b001000,
    S_START  = 6'b000001,
    S_READY  = 6'b010000,
    S_GRA    = 6'b000010,
    S_PAUSE  = 6'b100000,
    S_KONIEC = 6'b000100
  } state_t;

  localparam int MAX_FRAMES = (READY_FRAMES > END_FRAMES) ? READY_FRAMES : END_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_FRAMES - 1);
  localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(END_FRAMES - 1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic inc);
    return (inc && (v != 4'hF)) ? v + 4'd1 : v;
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       s1_n, s2_n, s1_inc, s2_inc;
  logic [1:0]       res_n;
  logic             p1_win, p2_win;

  logic vsync_q, tick;
  logic start_p0, start_p1, start_smp, start_press;
  logic pause_p0, pause_p1, pause_smp, pause_press;

  // Frame tick and button synchronizers; buttons are sampled once per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q   <= 1'b0;
      start_p0  <= 1'b0;
      start_p1  <= 1'b0;
      start_smp <= 1'b0;
      pause_p0  <= 1'b0;
      pause_p1  <= 1'b0;
      pause_smp <= 1'b0;
    end else begin
      vsync_q  <= vsync;
      start_p0 <= btn_start;
      start_p1 <= start_p0;
      pause_p0 <= btn_pause;
      pause_p1 <= pause_p0;
      if (tick) begin
        start_smp <= start_p1;
        pause_smp <= pause_p1;
      end
    end
  end

  assign tick        = vsync & ~vsync_q;
  assign start_press = tick & start_p1 & ~start_smp;
  assign pause_press = tick & pause_p1 & ~pause_smp;

  // Game state, scores, result and frame counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_INIT;
      cnt      <= '0;
      score_p1 <= 4'd0;
      score_p2 <= 4'd0;
      resoult  <= 2'b00;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      score_p1 <= s1_n;
      score_p2 <= s2_n;
      resoult  <= res_n;
    end
  end

  assign s1_inc = sat_inc(score_p1, p1_point);
  assign s2_inc = sat_inc(score_p2, p2_point);
  assign p1_win = (s1_inc >= WIN);
  assign p2_win = (s2_inc >= WIN);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    s1_n    = score_p1;
    s2_n    = score_p2;
    res_n   = resoult;
    case (state)
      S_INIT: begin
        if (tick) state_n = S_START;
      end
      S_START: begin
        if (start_press) begin
          state_n = S_READY;
          cnt_n   = '0;
          s1_n    = 4'd0;
          s2_n    = 4'd0;
          res_n   = 2'b00;
        end
      end
      S_READY: begin
        if (tick) begin
          if (cnt == READY_LAST) state_n = S_GRA;
          else                   cnt_n   = cnt + CNT_W'(1);
        end
      end
      S_GRA: begin
        s1_n = s1_inc;
        s2_n = s2_inc;
        // A win on the post-increment scores beats a pause press in the same cycle.
        if (p1_win || p2_win) begin
          state_n = S_KONIEC;
          res_n   = {p2_win, p1_win};
          cnt_n   = '0;
        end else if (pause_press) begin
          state_n = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_press) state_n = S_GRA;
      end
      S_KONIEC: begin
`ifdef GAME_CTL_TIMEOUT_EN
        if (start_press) begin
          state_n = S_START;
        end else if (tick) begin
          if (cnt == END_LAST) state_n = S_START;
          else                 cnt_n   = cnt + CNT_W'(1);
        end
`else
        if (start_press) state_n = S_START;
`endif
      end
      default: begin
        state_n = S_INIT;
      end
    endcase
  end

  assign state_bin = state;

endmodule
